// File: rtl/calendar_pkg.sv
// ----------------------------------------------------------------------------
// calendar_pkg
//   Shared definitions for the Gregorian calendar register:
//   - field widths for the day and month fields
//   - month constants JAN..DEC and the day-of-week encoding (0=Mon..6=Sun)
//   - month_len(), the number of days in a month for a given leap flag
//   Optional feature macro used by calendar_counter: DATE_DOW_EN
// ----------------------------------------------------------------------------
package calendar_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;

    typedef enum logic [MONTH_W-1:0] {
        JAN = 4'd1,  FEB = 4'd2,  MAR = 4'd3,  APR = 4'd4,
        MAY = 4'd5,  JUN = 4'd6,  JUL = 4'd7,  AUG = 4'd8,
        SEP = 4'd9,  OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
    } month_e;

    typedef enum logic [2:0] {
        MON = 3'd0, TUE = 3'd1, WED = 3'd2, THU = 3'd3,
        FRI = 3'd4, SAT = 3'd5, SUN = 3'd6
    } dow_e;

    // Returns 0 for an out-of-range month so that a load with a bad month
    // can never pass the day-range check by accident.
    function automatic logic [DAY_W-1:0] month_len(input logic [MONTH_W-1:0] month,
                                                   input logic               leap);
        logic [DAY_W-1:0] len;
        len = 5'd0;
        case (month)
            APR, JUN, SEP, NOV:                len = 5'd30;
            FEB:                               len = leap ? 5'd29 : 5'd28;
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: len = 5'd31;
            default:                           len = 5'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/calendar_leap_check.sv
// ----------------------------------------------------------------------------
// calendar_leap_check
//   Combinational leap-year decode. The stored year is offset by YEAR_BASE
//   to obtain the calendar year, then the full Gregorian rule is applied:
//   divisible by 4, except centuries, except every fourth century.
// Ports
//   i_year  in   YEAR_W  stored year (calendar year - YEAR_BASE)
//   o_leap  out  1       calendar year is a leap year
// ----------------------------------------------------------------------------
module calendar_leap_check #(
    parameter int YEAR_W    = 12,
    parameter int YEAR_BASE = 2000
) (
    input  logic [YEAR_W-1:0] i_year,
    output logic              o_leap
);

    logic [31:0] w_calYear;

    // 32 bits comfortably holds any stored year plus a realistic base year.
    assign w_calYear = 32'(i_year) + 32'(YEAR_BASE);

    assign o_leap = ((w_calYear % 32'd4) == 32'd0) &&
                    (((w_calYear % 32'd100) != 32'd0) || ((w_calYear % 32'd400) == 32'd0));

endmodule

// File: rtl/calendar_counter.sv
// ----------------------------------------------------------------------------
// calendar_counter
//   Gregorian calendar register. Advances day/month/year on a one-cycle
//   day_tick, validates loads against month length (leap rule evaluated on
//   the loaded year) and flags month, year and year-field rollover.
//   Optional feature: define DATE_DOW_EN to add a day-of-week register with
//   dow_in/dow_out ports. Without it DOW_RESET has no effect.
// Ports
//   clk        in   1          system clock, posedge
//   rst_n      in   1          synchronous reset, active-low
//   day_tick   in   1          advance the date by one day
//   load       in   1          overwrite the date with date_in (if valid)
//   date_in    in   9+YEAR_W   {day[4:0], month[3:0], year[YEAR_W-1:0]}
//   date_out   out  9+YEAR_W   current date, same format
//   leap       out  1          current year is a leap year
//   month_end  out  1          current day is the last day of the month
//   new_month  out  1          pulse: month just advanced
//   new_year   out  1          pulse: year just advanced
//   year_wrap  out  1          pulse: year field wrapped from all-ones to 0
//   load_err   out  1          pulse: load rejected
//   dow_in     in   3          day of week to load (DATE_DOW_EN)
//   dow_out    out  3          current day of week 0..6 (DATE_DOW_EN)
// ----------------------------------------------------------------------------
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W    = 12,
    parameter int YEAR_BASE = 2000,
    parameter int DOW_RESET = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                day_tick,
    input  logic                load,
    input  logic [8+YEAR_W:0]   date_in,
    output logic [8+YEAR_W:0]   date_out,
    output logic                leap,
    output logic                month_end,
    output logic                new_month,
    output logic                new_year,
    output logic                year_wrap,
`ifdef DATE_DOW_EN
    input  logic [2:0]          dow_in,
    output logic [2:0]          dow_out,
`endif
    output logic                load_err
);

    localparam logic [YEAR_W-1:0] YEAR_ONE = YEAR_W'(1);

    if (YEAR_BASE < 0) begin : g_badYearBase
        $error("calendar_counter: YEAR_BASE must be >= 0");
    end
    if ((DOW_RESET < 0) || (DOW_RESET > 6)) begin : g_badDowReset
        $error("calendar_counter: DOW_RESET must be in 0..6");
    end

    logic [DAY_W-1:0]   r_day;
    logic [MONTH_W-1:0] r_month;
    logic [YEAR_W-1:0]  r_year;
    logic               r_newMonth;
    logic               r_newYear;
    logic               r_yearWrap;
    logic               r_loadErr;

    logic [DAY_W-1:0]   w_inDay;
    logic [MONTH_W-1:0] w_inMonth;
    logic [YEAR_W-1:0]  w_inYear;
    logic               w_curLeap;
    logic               w_inLeap;
    logic [DAY_W-1:0]   w_curLen;
    logic [DAY_W-1:0]   w_inLen;
    logic               w_loadValid;

    assign w_inDay   = date_in[8+YEAR_W:4+YEAR_W];
    assign w_inMonth = date_in[3+YEAR_W:YEAR_W];
    assign w_inYear  = date_in[YEAR_W-1:0];

    calendar_leap_check #(
        .YEAR_W    (YEAR_W),
        .YEAR_BASE (YEAR_BASE)
    ) u_leapCur (
        .i_year (r_year),
        .o_leap (w_curLeap)
    );

    // Load validation must use the incoming year, not the current one,
    // so that 29-02 is judged against the year being loaded.
    calendar_leap_check #(
        .YEAR_W    (YEAR_W),
        .YEAR_BASE (YEAR_BASE)
    ) u_leapLoad (
        .i_year (w_inYear),
        .o_leap (w_inLeap)
    );

    assign w_curLen = month_len(r_month, w_curLeap);
    assign w_inLen  = month_len(w_inMonth, w_inLeap);

    // month_len() returns 0 for months outside 1..12, so the day-range test
    // alone also rejects bad months; the explicit month test keeps intent clear.
`ifdef DATE_DOW_EN
    assign w_loadValid = (w_inMonth >= JAN) && (w_inMonth <= DEC) &&
                         (w_inDay != 5'd0) && (w_inDay <= w_inLen) &&
                         (dow_in != 3'd7);
`else
    assign w_loadValid = (w_inMonth >= JAN) && (w_inMonth <= DEC) &&
                         (w_inDay != 5'd0) && (w_inDay <= w_inLen);
`endif

    // Date register. Reset beats load, load beats tick; all pulses default
    // low every cycle so each lasts exactly one clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_day      <= 5'd1;
            r_month    <= JAN;
            r_year     <= '0;
            r_newMonth <= 1'b0;
            r_newYear  <= 1'b0;
            r_yearWrap <= 1'b0;
            r_loadErr  <= 1'b0;
        end else begin
            r_newMonth <= 1'b0;
            r_newYear  <= 1'b0;
            r_yearWrap <= 1'b0;
            r_loadErr  <= 1'b0;
            if (load) begin
                if (w_loadValid) begin
                    r_day   <= w_inDay;
                    r_month <= w_inMonth;
                    r_year  <= w_inYear;
                end else begin
                    r_loadErr <= 1'b1;
                end
            end else if (day_tick) begin
                if (r_day < w_curLen) begin
                    r_day <= r_day + 5'd1;
                end else begin
                    r_day      <= 5'd1;
                    r_newMonth <= 1'b1;
                    if (r_month == DEC) begin
                        r_month   <= JAN;
                        r_year    <= r_year + YEAR_ONE;
                        r_newYear <= 1'b1;
                        if (&r_year) begin
                            r_yearWrap <= 1'b1;
                        end
                    end else begin
                        r_month <= r_month + 4'd1;
                    end
                end
            end
        end
    end

`ifdef DATE_DOW_EN
    logic [2:0] r_dow;

    // Day of week follows the same load/tick priority as the date.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dow <= 3'(DOW_RESET);
        end else if (load) begin
            if (w_loadValid) begin
                r_dow <= dow_in;
            end
        end else if (day_tick) begin
            r_dow <= (r_dow == SUN) ? MON : (r_dow + 3'd1);
        end
    end

    assign dow_out = r_dow;
`endif

    assign date_out  = {r_day, r_month, r_year};
    assign leap      = w_curLeap;
    assign month_end = (r_day == w_curLen);
    assign new_month = r_newMonth;
    assign new_year  = r_newYear;
    assign year_wrap = r_yearWrap;
    assign load_err  = r_loadErr;

endmodule
